// File: rtl/npu_pool_pkg.sv
// npu_pool_pkg: shared types and helpers for the pooling stage.
//   state_t : IDLE/RUN/DONE frame FSM encoding (2 bits)
//   PIX_W   : requantized pixel width
//   max8    : unsigned 8-bit maximum
package npu_pool_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int PIX_W = 8;
  function automatic logic [PIX_W-1:0] max8(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/relu_requant.sv
// relu_requant: ReLU, arithmetic right shift and saturation to an 8-bit pixel.
//   data : signed accumulator in
//   pix  : unsigned requantized pixel out (0 for negatives, clipped at 255)
module relu_requant import npu_pool_pkg::*; #(
  parameter int ACC_W = 16,
  parameter int SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] data,
  output logic [PIX_W-1:0]        pix
);
  logic signed [ACC_W-1:0] sh;
  assign sh  = data >>> SHIFT;
  assign pix = data[ACC_W-1] ? '0 : (sh > 255) ? '1 : PIX_W'(sh);
endmodule

// File: rtl/relu_maxpool.sv
// relu_maxpool: ReLU + requant + 2x2/stride-2 max pooling of a row-major map.
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_start, i_out_start_addr : frame start (IDLE only) and pooled-map base
//   i_in_valid, o_in_ready, i_in_data : accumulator input stream
//   o_wr_en, o_wr_addr, o_wr_data     : pooled pixel write port
//   o_busy, o_done          : RUN indicator, one-cycle end-of-frame pulse
module relu_maxpool import npu_pool_pkg::*; #(
  parameter int ACC_W  = 16,
  parameter int MAP_W  = 26,
  parameter int MAP_H  = 26,
  parameter int SHIFT  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_out_start_addr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [ACC_W-1:0]  i_in_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [PIX_W-1:0]  o_wr_data,
  output logic              o_busy,
  output logic              o_done
);
  localparam int CW = $clog2(MAP_W + 1);
  localparam int RW = $clog2(MAP_H + 1);
  localparam int BW = (MAP_W / 2 > 1) ? $clog2(MAP_W / 2) : 1;
  state_t state, next;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [ADDR_W-1:0] base;
  logic [PIX_W-1:0] q, hold, rb_q;
  logic [PIX_W-1:0] rowbuf [MAP_W/2];
  logic [BW-1:0] idx;
  logic beat, col_end, last;
  relu_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_rq (.data(i_in_data), .pix(q));
  assign beat    = i_in_valid & o_in_ready;
  assign col_end = col == CW'(MAP_W - 1);
  assign last    = col_end && row == RW'(MAP_H - 1);
  assign idx     = BW'(col >> 1);
  assign rb_q    = rowbuf[idx];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= next;
  always_comb
    next = (state == IDLE && i_start) ? RUN :
           (state == RUN && beat && last) ? DONE :
           (state == DONE) ? IDLE : state;
  always_comb begin
    o_in_ready = state == RUN;
    o_busy     = state == RUN;
    o_done     = state == DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      base      <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= beat & row[0] & col[0];
      if (state == IDLE && i_start) begin
        base <= i_out_start_addr;
        col  <= '0;
        row  <= '0;
      end else if (beat) begin
        col <= col_end ? '0 : col + 1'b1;
        row <= col_end ? row + 1'b1 : row;
        if (!col[0]) hold <= q;
        // Odd row, odd col closes a window: top pair from the row buffer, bottom pair from hold/q.
        if (row[0] & col[0]) begin
          o_wr_data <= max8(rb_q, max8(hold, q));
          o_wr_addr <= ADDR_W'(32'(base) + 32'(row >> 1) * (MAP_W / 2) + 32'(col >> 1));
        end
      end
    end
  // Row buffer keeps the top-row pair maxima; no reset since it is always written before read.
  always_ff @(posedge i_clk)
    if (beat && !row[0] && col[0]) rowbuf[idx] <= max8(hold, q);
endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: scoreboard bench driving a 4x4/SHIFT=0 and a 5x5/SHIFT=4 instance.
module tb_relu_maxpool;
  logic clk = 0, rst_n = 0;
  logic start_a = 0, valid_a = 0, ready_a, wr_en_a, busy_a, done_a;
  logic [7:0] base_a = 0, wr_addr_a, wr_data_a;
  logic [15:0] data_a = 0;
  logic start_b = 0, valid_b = 0, ready_b, wr_en_b, busy_b, done_b;
  logic [7:0] base_b = 0, wr_addr_b, wr_data_b;
  logic [15:0] data_b = 0;
  logic [15:0] q_a [$];
  logic [15:0] q_b [$];
  logic [15:0] ea, eb;
  int px [64];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  relu_maxpool #(.ACC_W(16), .MAP_W(4), .MAP_H(4), .SHIFT(0), .ADDR_W(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_out_start_addr(base_a),
    .i_in_valid(valid_a), .o_in_ready(ready_a), .i_in_data(data_a),
    .o_wr_en(wr_en_a), .o_wr_addr(wr_addr_a), .o_wr_data(wr_data_a),
    .o_busy(busy_a), .o_done(done_a));
  relu_maxpool #(.ACC_W(16), .MAP_W(5), .MAP_H(5), .SHIFT(4), .ADDR_W(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_out_start_addr(base_b),
    .i_in_valid(valid_b), .o_in_ready(ready_b), .i_in_data(data_b),
    .o_wr_en(wr_en_b), .o_wr_addr(wr_addr_b), .o_wr_data(wr_data_b),
    .o_busy(busy_b), .o_done(done_b));
  always @(negedge clk) begin
    if (wr_en_a) begin
      ea = (q_a.size() != 0) ? q_a.pop_front() : 16'hxxxx;
      total++;
      assert ({wr_addr_a, wr_data_a} === ea) else begin
        bad++;
        $error("FAIL wr_a addr_data obs=%h exp=%h", {wr_addr_a, wr_data_a}, ea);
      end
    end
    if (wr_en_b) begin
      eb = (q_b.size() != 0) ? q_b.pop_front() : 16'hxxxx;
      total++;
      assert ({wr_addr_b, wr_data_b} === eb) else begin
        bad++;
        $error("FAIL wr_b addr_data obs=%h exp=%h", {wr_addr_b, wr_data_b}, eb);
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit sel, input logic v, input int d, input logic s, input int b);
    if (sel) begin
      valid_b = v; data_b = 16'(d); start_b = s; base_b = 8'(b);
    end else begin
      valid_a = v; data_a = 16'(d); start_a = s; base_a = 8'(b);
    end
  endtask
  function automatic int rq(input int x, input int sh);
    int y;
    y = x >>> sh;
    return (x < 0) ? 0 : (y > 255) ? 255 : y;
  endfunction
  task automatic model(input bit sel, input int base, input int w, input int h, input int sh);
    int m, v;
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++) begin
        m = 0;
        for (int k = 0; k < 4; k++) begin
          v = rq(px[(2 * r + k / 2) * w + 2 * c + k % 2], sh);
          if (v > m) m = v;
        end
        if (sel) q_b.push_back({8'(base + r * (w / 2) + c), 8'(m)});
        else q_a.push_back({8'(base + r * (w / 2) + c), 8'(m)});
      end
  endtask
  // stop_at >= 0 abandons the frame after that many beats; mid_at pulses i_start during that beat.
  task automatic run_frame(input bit sel, input int base, input int w, input int h, input int sh,
                           input bit gaps, input int stop_at, input int mid_at);
    if (stop_at < 0) model(sel, base, w, h, sh);
    drive(sel, 0, 0, 1, base);
    @(posedge clk); #1;
    drive(sel, 0, 0, 0, 0);
    for (int i = 0; i < w * h; i++) begin
      if (i == stop_at) return;
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      chk(sel ? "ready_b" : "ready_a", sel ? ready_b : ready_a, 1);
      drive(sel, 1, px[i], i == mid_at, 8'h80);
      @(posedge clk); #1;
      drive(sel, 0, 0, 0, 0);
    end
    chk("done_pulse", sel ? done_b : done_a, 1);
    chk("busy_in_done", sel ? busy_b : busy_a, 0);
    @(posedge clk); #1;
    chk("done_clear", sel ? done_b : done_a, 0);
    chk("ready_idle", sel ? ready_b : ready_a, 0);
    chk("queue_drained", sel ? q_b.size() : q_a.size(), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_a, 0);
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_wr_addr", wr_addr_a, 0);
    chk("rst_wr_data", wr_data_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_b_ready", ready_b, 0);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) px[i] = i;
    run_frame(0, 'h10, 4, 4, 0, 0, -1, -1);
    run_frame(0, 'hFE, 4, 4, 0, 0, -1, -1);
    for (int i = 0; i < 16; i++) px[i] = -100;
    run_frame(0, 'h20, 4, 4, 0, 0, -1, -1);
    for (int i = 0; i < 16; i++) px[i] = -9;
    px[0] = -5; px[1] = -1; px[4] = -7; px[5] = 3;
    run_frame(0, 'h30, 4, 4, 0, 0, -1, -1);
    for (int i = 0; i < 16; i++) px[i] = i;
    run_frame(0, 'h10, 4, 4, 0, 1, -1, -1);
    for (int i = 0; i < 25; i++) px[i] = i * 16;
    run_frame(1, 'h40, 5, 5, 4, 0, -1, -1);
    for (int i = 0; i < 25; i++) px[i] = 80;
    px[0] = 5000;
    run_frame(1, 'h50, 5, 5, 4, 1, -1, -1);
    for (int i = 0; i < 16; i++) px[i] = 200 - i;
    run_frame(0, 'h60, 4, 4, 0, 0, 6, -1);
    rst_n = 0;
    #1;
    chk("midrst_wr_en", wr_en_a, 0);
    chk("midrst_busy", busy_a, 0);
    @(posedge clk); #1;
    chk("midrst_ready", ready_a, 0);
    chk("midrst_wr_en_edge", wr_en_a, 0);
    chk("midrst_wr_addr", wr_addr_a, 0);
    chk("midrst_wr_data", wr_data_a, 0);
    chk("midrst_done", done_a, 0);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) px[i] = i;
    run_frame(0, 'h00, 4, 4, 0, 0, -1, 9);
    repeat (3) @(posedge clk);
    #1;
    chk("final_q_a", q_a.size(), 0);
    chk("final_q_b", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
